zacore_fetch: RTL and testbench

//  Fetch stage of the zacore 5-stage pipeline; the producer end of fetch_decode_if_t.

---
 rtl/zacore_fetch.sv | 114 +++++++++++
 tb/tb_zacore_fetch.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/zacore_fetch.sv
// zacore fetch stage: holds the PC, keeps one imem request outstanding, and registers
// each returned instruction with its PC for decode. Execute redirects squash wrong-path work.
module zacore_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        o_imem_req_valid,
  input  logic        i_imem_req_ready,
  output logic [29:0] o_imem_req_addr,
  input  logic        i_imem_rsp_valid,
  input  logic [31:0] i_imem_rsp_data,
  input  logic [32:0] i_execute_fetch,
  output logic [64:0] o_fetch_decode,
  input  logic        i_decode_ready
);

  typedef enum logic [1:0] {
    ST_REQ,
    ST_WAIT,
    ST_DRAIN
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        fdValid_q, fdValid_d;
  logic [31:0] fdPc_q, fdPc_d;
  logic [31:0] fdInst_q, fdInst_d;
  logic        lateRspOk_q;

  logic        redirect;
  logic [31:0] redirectPc;
  logic        reqFire;

  assign redirect   = i_execute_fetch[32];
  assign redirectPc = {i_execute_fetch[31:2], 2'b00};

  assign o_imem_req_valid = rst_n && (state_q == ST_REQ) && (!fdValid_q || i_decode_ready);
  assign o_imem_req_addr  = pc_q[31:2];
  assign reqFire          = o_imem_req_valid && i_imem_req_ready;
  assign o_fetch_decode   = {fdValid_q, fdPc_q, fdInst_q};

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    fdValid_d = fdValid_q && !i_decode_ready;
    fdPc_d    = fdPc_q;
    fdInst_d  = fdInst_q;

    if (redirect) begin
      pc_d      = redirectPc;
      fdValid_d = 1'b0;
      unique case (state_q)
        ST_REQ:   state_d = reqFire ? ST_DRAIN : ST_REQ;
        ST_WAIT:  state_d = i_imem_rsp_valid ? ST_REQ : ST_DRAIN;
        ST_DRAIN: state_d = i_imem_rsp_valid ? ST_REQ : ST_DRAIN;
        default:  state_d = ST_REQ;
      endcase
    end else begin
      unique case (state_q)
        ST_REQ: begin
          if (reqFire) state_d = ST_WAIT;
        end
        ST_WAIT: begin
          // The request was only issued with the output register free, so this never overwrites live data.
          if (i_imem_rsp_valid) begin
            fdValid_d = 1'b1;
            fdPc_d    = pc_q;
            fdInst_d  = i_imem_rsp_data;
            pc_d      = pc_q + 32'd4;
            state_d   = ST_REQ;
          end
        end
        ST_DRAIN: begin
          if (i_imem_rsp_valid) state_d = ST_REQ;
        end
        default: state_d = ST_REQ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_REQ;
      pc_q      <= RESET_PC & ~32'd3;
      fdValid_q <= 1'b0;
      fdPc_q    <= '0;
      fdInst_q  <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      fdValid_q <= fdValid_d;
      fdPc_q    <= fdPc_d;
      fdInst_q  <= fdInst_d;
    end
  end

  // Remembers that a reset cut off an outstanding request, so its late response is expected.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lateRspOk_q <= lateRspOk_q || (state_q != ST_REQ);
    end else if (i_imem_rsp_valid) begin
      lateRspOk_q <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n && (state_q == ST_REQ) && i_imem_rsp_valid) begin
      assert (lateRspOk_q)
        else $error("zacore_fetch: imem response with no request outstanding");
    end
  end

endmodule

// File: tb/tb_zacore_fetch.sv
// Directed bench for zacore_fetch: sequential fetch, decode stall, redirects, PC wrap
// and reset while a request is outstanding.
module tb_zacore_fetch;

  logic        clk;
  logic        rst_n;
  logic        reqValid;
  logic        reqReady;
  logic [29:0] reqAddr;
  logic        rspValid;
  logic [31:0] rspData;
  logic [32:0] executeFetch;
  logic [64:0] fetchDecode;
  logic        decodeReady;

  int checks = 0;
  int errors = 0;

  zacore_fetch #(.RESET_PC(32'h1000)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .o_imem_req_valid (reqValid),
    .i_imem_req_ready (reqReady),
    .o_imem_req_addr  (reqAddr),
    .i_imem_rsp_valid (rspValid),
    .i_imem_rsp_data  (rspData),
    .i_execute_fetch  (executeFetch),
    .o_fetch_decode   (fetchDecode),
    .i_decode_ready   (decodeReady)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change 1ns after the rising edge so checks never race the active edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic rstN, input logic ready, input logic rspV,
                               input logic [31:0] data, input logic redir,
                               input logic [31:0] target, input logic decReady);
    rst_n        = rstN;
    reqReady     = ready;
    rspValid     = rspV;
    rspData      = data;
    executeFetch = {redir, target};
    decodeReady  = decReady;
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [64:0] observed, input logic [64:0] expected);
    checks++;
    assert (observed === expected)
      else begin
        errors++;
        $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
      end
  endtask

  initial begin
    applyStimulus(0, 1, 0, 32'h0, 0, 32'h0, 1);
    tick();
    tick();
    checkOutput("rst_reqvalid", 65'(reqValid), 65'(0));
    checkOutput("rst_fd", fetchDecode, 65'h0);
    checkOutput("rst_addr", 65'(reqAddr), 65'(30'h400));

    // 1: sequential fetch from 0x1000
    applyStimulus(1, 1, 0, 32'h0, 0, 32'h0, 1);
    checkOutput("t1_req0", 65'(reqValid), 65'(1));
    tick();
    applyStimulus(1, 1, 1, 32'hA000_0000, 0, 32'h0, 1);
    checkOutput("t1_wait_noreq", 65'(reqValid), 65'(0));
    tick();
    applyStimulus(1, 1, 0, 32'h0, 0, 32'h0, 1);
    checkOutput("t1_out0", fetchDecode, {1'b1, 32'h1000, 32'hA000_0000});
    checkOutput("t1_addr1", 65'(reqAddr), 65'(30'h401));
    checkOutput("t1_req1", 65'(reqValid), 65'(1));
    tick();
    checkOutput("t1_consumed", 65'(fetchDecode[64]), 65'(0));
    applyStimulus(1, 1, 1, 32'hA000_0001, 0, 32'h0, 1);
    tick();
    applyStimulus(1, 1, 0, 32'h0, 0, 32'h0, 1);
    checkOutput("t1_out1", fetchDecode, {1'b1, 32'h1004, 32'hA000_0001});
    tick();
    applyStimulus(1, 1, 1, 32'hA000_0002, 0, 32'h0, 1);
    tick();
    checkOutput("t1_out2", fetchDecode, {1'b1, 32'h1008, 32'hA000_0002});

    // 2: decode stall holds the output and blocks issue
    applyStimulus(1, 1, 0, 32'h0, 0, 32'h0, 0);
    checkOutput("t2_noreq", 65'(reqValid), 65'(0));
    tick();
    checkOutput("t2_hold1", fetchDecode, {1'b1, 32'h1008, 32'hA000_0002});
    tick();
    checkOutput("t2_hold2", fetchDecode, {1'b1, 32'h1008, 32'hA000_0002});
    checkOutput("t2_noreq2", 65'(reqValid), 65'(0));
    applyStimulus(1, 1, 0, 32'h0, 0, 32'h0, 1);
    checkOutput("t2_release_req", 65'(reqValid), 65'(1));
    checkOutput("t2_release_addr", 65'(reqAddr), 65'(30'h403));
    tick();

    // 3: redirect to 0x2002 while waiting; stale response dropped
    applyStimulus(1, 1, 0, 32'h0, 1, 32'h2002, 1);
    tick();
    applyStimulus(1, 1, 0, 32'h0, 0, 32'h0, 1);
    checkOutput("t3_drain_noreq", 65'(reqValid), 65'(0));
    checkOutput("t3_addr", 65'(reqAddr), 65'(30'h800));
    applyStimulus(1, 1, 1, 32'hDEAD_BEEF, 0, 32'h0, 1);
    tick();
    applyStimulus(1, 1, 0, 32'h0, 0, 32'h0, 1);
    checkOutput("t3_stale_dropped", 65'(fetchDecode[64]), 65'(0));
    checkOutput("t3_req", 65'(reqValid), 65'(1));
    tick();
    applyStimulus(1, 1, 1, 32'hB000_0000, 0, 32'h0, 1);
    tick();
    applyStimulus(1, 1, 0, 32'h0, 0, 32'h0, 1);
    checkOutput("t3_out", fetchDecode, {1'b1, 32'h2000, 32'hB000_0000});

    // 4: redirect coincident with the response
    tick();
    applyStimulus(1, 1, 1, 32'hC000_0000, 1, 32'h3000, 1);
    checkOutput("t4_empty", 65'(fetchDecode[64]), 65'(0));
    tick();
    applyStimulus(1, 1, 0, 32'h0, 0, 32'h0, 1);
    checkOutput("t4_no_output", 65'(fetchDecode[64]), 65'(0));
    checkOutput("t4_req", 65'(reqValid), 65'(1));
    checkOutput("t4_addr", 65'(reqAddr), 65'(30'hC00));

    // 5: redirect to the top word (not accepted in REQ), then wrap
    applyStimulus(1, 0, 0, 32'h0, 1, 32'hFFFF_FFFC, 1);
    tick();
    applyStimulus(1, 1, 0, 32'h0, 0, 32'h0, 1);
    checkOutput("t5_addr_top", 65'(reqAddr), 65'(30'h3FFF_FFFF));
    tick();
    applyStimulus(1, 1, 1, 32'hD000_0000, 0, 32'h0, 1);
    tick();
    applyStimulus(1, 1, 0, 32'h0, 0, 32'h0, 0);
    checkOutput("t5_out", fetchDecode, {1'b1, 32'hFFFF_FFFC, 32'hD000_0000});
    checkOutput("t5_wrap", 65'(reqAddr), 65'(30'h0));

    // Redirect squashes an output held by a stalled decode
    applyStimulus(1, 1, 0, 32'h0, 1, 32'h4000, 0);
    tick();
    applyStimulus(1, 1, 0, 32'h0, 0, 32'h0, 0);
    checkOutput("sq_held", 65'(fetchDecode[64]), 65'(0));
    checkOutput("sq_req", 65'(reqValid), 65'(1));
    checkOutput("sq_addr", 65'(reqAddr), 65'(30'h1000));

    // Redirect in the same cycle as an accepted request
    applyStimulus(1, 1, 0, 32'h0, 1, 32'h5000, 1);
    tick();
    applyStimulus(1, 1, 1, 32'h1234_5678, 0, 32'h0, 1);
    checkOutput("acc_redir_drain", 65'(reqValid), 65'(0));
    checkOutput("acc_redir_addr", 65'(reqAddr), 65'(30'h1400));
    tick();
    applyStimulus(1, 1, 0, 32'h0, 0, 32'h0, 1);
    checkOutput("acc_redir_dropped", 65'(fetchDecode[64]), 65'(0));
    checkOutput("acc_redir_req", 65'(reqValid), 65'(1));

    // 6: reset during WAIT, late response afterwards
    tick();
    applyStimulus(0, 1, 0, 32'h0, 0, 32'h0, 1);
    checkOutput("t6_rst_noreq", 65'(reqValid), 65'(0));
    tick();
    applyStimulus(1, 0, 1, 32'hEEEE_EEEE, 0, 32'h0, 1);
    checkOutput("t6_fd_clear", fetchDecode, 65'h0);
    checkOutput("t6_addr", 65'(reqAddr), 65'(30'h400));
    checkOutput("t6_req", 65'(reqValid), 65'(1));
    tick();
    applyStimulus(1, 1, 0, 32'h0, 0, 32'h0, 1);
    checkOutput("t6_late_ignored", fetchDecode, 65'h0);
    checkOutput("t6_req_again", 65'(reqValid), 65'(1));
    checkOutput("t6_addr_again", 65'(reqAddr), 65'(30'h400));
    tick();
    applyStimulus(1, 1, 1, 32'hF000_0000, 0, 32'h0, 1);
    checkOutput("t6_wait_empty", 65'(fetchDecode[64]), 65'(0));
    tick();
    applyStimulus(1, 1, 0, 32'h0, 0, 32'h0, 1);
    checkOutput("t6_out", fetchDecode, {1'b1, 32'h1000, 32'hF000_0000});

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
